// File: rtl/lcd_bus_monitor.sv
// ----------------------------------------------------------------------------
// lcd_bus_monitor
//   Receive-side model of a 4-bit character-LCD bus. It watches the
//   LCD_E/LCD_RS/LCD_RW/SF_D lines driven by an LCD controller, walks the
//   0x3,0x3,0x3,0x2 wake-up sequence, then pairs nibbles into bytes, tracks
//   the DDRAM cursor and flags protocol/timing violations as sticky bits.
//
// Ports
//   clk          system clock (single domain)
//   reset        synchronous, active-high
//   LCD_E        enable strobe; a byte/nibble is taken on its falling edge
//   LCD_RS       0 = command, 1 = data
//   LCD_RW       must be 0; a strobe with RW=1 is flagged and ignored
//   SF_D[3:0]    data nibble
//   byte_valid   one-cycle strobe qualifying byte_rs/byte_data/byte_addr
//   byte_rs      RS of the emitted byte
//   byte_data    assembled byte {upper, lower}
//   byte_addr    DDRAM address written by a data byte (0 for commands)
//   ddram_addr   current cursor address
//   mode_4bit    wake-up complete, nibble pairing active
//   err_pulse    sticky: E high shorter than E_MIN_HIGH
//   err_gap      sticky: inter-strobe gap too short
//   err_rw       sticky: strobe seen with LCD_RW=1
//   err_seq      sticky: bad wake-up nibble or RS mismatch within a pair
// ----------------------------------------------------------------------------
module lcd_bus_monitor #(
    parameter int E_MIN_HIGH    = 12,
    parameter int NIB_GAP_MIN   = 50,
    parameter int CMD_GAP_MIN   = 2000,
    parameter int CLEAR_GAP_MIN = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [3:0] SF_D,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic [6:0] byte_addr,
    output logic [6:0] ddram_addr,
    output logic       mode_4bit,
    output logic       err_pulse,
    output logic       err_gap,
    output logic       err_rw,
    output logic       err_seq
);

    typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, S_HI, S_LO} state_t;

    state_t      state;

    // First stage registers the bus; second stage holds the values from the
    // previous cycle, so at a detected fall it still carries the nibble/RS/RW
    // sampled on the last edge that saw E high.
    logic        e_q, rs_q, rw_q;
    logic [3:0]  d_q;
    logic        e_p, rs_p, rw_p;
    logic [3:0]  d_p;

    logic [15:0] hi_cnt;
    logic [16:0] gap_cnt;
    logic [3:0]  upper;
    logic        upper_rs;
    logic        last_clear;   // last emitted byte was command 0x01..0x03

    logic        fall, rise;
    logic [16:0] gap_min;
    logic [7:0]  assembled;
    logic [3:0]  init_nib;

    assign fall      = e_p & ~e_q;
    assign rise      = e_q & ~e_p;
    assign assembled = {upper, d_p};
    assign init_nib  = (state == INIT3) ? 4'h2 : 4'h3;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        gap_min = '0;
        case (state)
            S_LO:    gap_min = 17'(NIB_GAP_MIN);
            S_HI:    gap_min = last_clear ? 17'(CLEAR_GAP_MIN) : 17'(CMD_GAP_MIN);
            default: gap_min = '0;
        endcase
    end

    // Cursor advance with the 2-line wrap of a 2x40 display.
    function automatic logic [6:0] next_addr(input logic [6:0] a);
        if (a == 7'h27)      return 7'h40;
        else if (a == 7'h67) return 7'h00;
        else                 return a + 7'd1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            d_q        <= '0;
            e_p        <= 1'b0;
            rs_p       <= 1'b0;
            rw_p       <= 1'b0;
            d_p        <= '0;
            hi_cnt     <= '0;
            gap_cnt    <= '1;   // saturated: first strobe never trips err_gap
            state      <= INIT0;
            upper      <= '0;
            upper_rs   <= 1'b0;
            last_clear <= 1'b0;
            byte_valid <= 1'b0;
            byte_rs    <= 1'b0;
            byte_data  <= '0;
            byte_addr  <= '0;
            ddram_addr <= '0;
            mode_4bit  <= 1'b0;
            err_pulse  <= 1'b0;
            err_gap    <= 1'b0;
            err_rw     <= 1'b0;
            err_seq    <= 1'b0;
        end else begin
            e_q  <= LCD_E;
            rs_q <= LCD_RS;
            rw_q <= LCD_RW;
            d_q  <= SF_D;
            e_p  <= e_q;
            rs_p <= rs_q;
            rw_p <= rw_q;
            d_p  <= d_q;

            byte_valid <= 1'b0;

            if (e_q) begin
                if (hi_cnt != '1) hi_cnt <= hi_cnt + 16'd1;
            end else begin
                hi_cnt <= '0;
            end

            if (gap_cnt != '1) gap_cnt <= gap_cnt + 17'd1;

            if (rise && (gap_cnt < gap_min)) err_gap <= 1'b1;

            if (fall) begin
                if (rw_p) begin
                    // Read strobes are flagged only; state, cursor and the
                    // gap reference are left untouched.
                    err_rw <= 1'b1;
                end else begin
                    gap_cnt <= '0;
                    if (hi_cnt < 16'(E_MIN_HIGH)) err_pulse <= 1'b1;

                    case (state)
                        INIT0, INIT1, INIT2, INIT3: begin
                            if (d_p == init_nib && !rs_p) begin
                                case (state)
                                    INIT0:   state <= INIT1;
                                    INIT1:   state <= INIT2;
                                    INIT2:   state <= INIT3;
                                    default: begin
                                        state     <= S_HI;
                                        mode_4bit <= 1'b1;
                                    end
                                endcase
                            end else begin
                                // A stray 0x3 is treated as the first wake-up nibble.
                                err_seq <= 1'b1;
                                state   <= (d_p == 4'h3) ? INIT1 : INIT0;
                            end
                        end
                        S_HI: begin
                            upper    <= d_p;
                            upper_rs <= rs_p;
                            state    <= S_LO;
                        end
                        default: begin   // S_LO
                            state <= S_HI;
                            if (rs_p != upper_rs) begin
                                err_seq <= 1'b1;
                            end else begin
                                byte_valid <= 1'b1;
                                byte_rs    <= upper_rs;
                                byte_data  <= assembled;
                                if (upper_rs) begin
                                    byte_addr  <= ddram_addr;
                                    ddram_addr <= next_addr(ddram_addr);
                                    last_clear <= 1'b0;
                                end else begin
                                    byte_addr  <= '0;
                                    last_clear <= (assembled inside {8'h01, 8'h02, 8'h03});
                                    if (assembled[7])
                                        ddram_addr <= assembled[6:0];
                                    else if (assembled inside {8'h01, 8'h02, 8'h03})
                                        ddram_addr <= '0;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule
